rca_fault_sequencer: RTL and testbench

//  Test-side companion of the online checker / mask-signal generator for the 4-bit fault-tolerant RCA.

---
 rtl/rca_fault_sequencer.sv | 145 ++++++++++++++
 tb/tb_rca_fault_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_fault_sequencer.sv
// Pattern sequencer for the fault-tolerant 4-bit RCA: drives table operands, compares the adder's
// per-stage sum/carry against a golden ripple model and reports registered per-bit fault flags.
module rca_fault_sequencer #(
  parameter int NUM_PAT = 8,
  parameter int SETTLE  = 2,
  parameter int LOOP    = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       hold,
  input  logic [3:0] dut_s,
  input  logic [3:0] dut_c,
  output logic [3:0] pat_a,
  output logic [3:0] pat_b,
  output logic       pat_cin,
  output logic [2:0] lut_i,
  output logic [3:0] sf,
  output logic [3:0] cf,
  output logic       flag_vld,
  output logic       busy,
  output logic       done,
  output logic       fault_any
);

  localparam int            CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(SETTLE - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_PAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_wait;
  logic [2:0]    r_idx;
  logic [3:0]    r_sf;
  logic [3:0]    r_cf;
  logic          r_flag_pend;
  logic          r_fault_any;

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic       w_cin;
  logic [7:0] w_gold;
  logic [3:0] w_sf;
  logic [3:0] w_cf;
  logic       w_last;
  logic       w_settled;

  function automatic logic [8:0] pat_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    return {4'b0000, 4'b0000, 1'b0};
      3'd1:    return {4'b1111, 4'b0000, 1'b1};
      3'd2:    return {4'b1111, 4'b1111, 1'b0};
      3'd3:    return {4'b1010, 4'b0101, 1'b0};
      3'd4:    return {4'b0101, 4'b1010, 1'b1};
      3'd5:    return {4'b1111, 4'b0001, 1'b0};
      3'd6:    return {4'b0000, 4'b1111, 1'b1};
      default: return {4'b1100, 4'b0011, 1'b0};
    endcase
  endfunction

  // Returns {carry-out per stage, sum per stage}.
  function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] s;
    logic [3:0] c;
    logic       k;
    k = cin;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ k;
      c[i] = (a[i] & b[i]) | (a[i] & k) | (b[i] & k);
      k    = c[i];
    end
    return {c, s};
  endfunction

  assign {w_a, w_b, w_cin} = pat_entry(r_idx);
  assign w_gold    = golden(w_a, w_b, w_cin);
  assign w_sf      = dut_s ^ w_gold[3:0];
  assign w_cf      = dut_c ^ w_gold[7:4];
  assign w_last    = (r_idx == IDX_LAST);
  assign w_settled = (r_wait == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!hold) begin
      case (r_state)
        S_IDLE:  if (start) w_state_next = S_DRIVE;
        S_DRIVE: if (w_settled) w_state_next = S_CHECK;
        S_CHECK: w_state_next = (!w_last || LOOP != 0) ? S_DRIVE : S_DONE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // A strobe set on a check edge stays pending until an edge with hold low retires it.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wait      <= '0;
      r_idx       <= '0;
      r_sf        <= '0;
      r_cf        <= '0;
      r_flag_pend <= 1'b0;
      r_fault_any <= 1'b0;
    end else if (!hold) begin
      r_flag_pend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx       <= '0;
            r_wait      <= '0;
            r_fault_any <= 1'b0;
          end
        end
        S_DRIVE: r_wait <= w_settled ? '0 : r_wait + 1'b1;
        S_CHECK: begin
          r_sf        <= w_sf;
          r_cf        <= w_cf;
          r_flag_pend <= 1'b1;
          r_fault_any <= r_fault_any | (|(w_sf | w_cf));
          if (!w_last)       r_idx <= r_idx + 3'd1;
          else if (LOOP != 0) r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign pat_a     = busy ? w_a : 4'd0;
  assign pat_b     = busy ? w_b : 4'd0;
  assign pat_cin   = busy & w_cin;
  assign lut_i     = busy ? r_idx : 3'd0;
  assign sf        = r_sf;
  assign cf        = r_cf;
  assign fault_any = r_fault_any;
  assign flag_vld  = r_flag_pend & ~hold;
  assign done      = (r_state == S_DONE) & ~hold;

endmodule

// File: tb/tb_rca_fault_sequencer.sv
// Bench for rca_fault_sequencer: a timeline model (effective cycles since start) checked every cycle,
// plus directed runs with literal flag timings and fault patterns.
module tb_rca_fault_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_v      [2];
  logic       start_v    [2];
  logic       hold_v     [2];
  logic [3:0] dut_s_v    [2];
  logic [3:0] dut_c_v    [2];
  logic [3:0] pat_a_v    [2];
  logic [3:0] pat_b_v    [2];
  logic       pat_cin_v  [2];
  logic [2:0] lut_i_v    [2];
  logic [3:0] sf_v       [2];
  logic [3:0] cf_v       [2];
  logic       flag_vld_v [2];
  logic       busy_v     [2];
  logic       done_v     [2];
  logic       fault_any_v[2];
  logic [3:0] sa_s;
  logic [3:0] sa_c;

  logic [3:0] tbl_a  [8] = '{4'h0, 4'hF, 4'hF, 4'hA, 4'h5, 4'hF, 4'h0, 4'hC};
  logic [3:0] tbl_b  [8] = '{4'h0, 4'h0, 4'hF, 4'h5, 4'hA, 4'h1, 4'hF, 4'h3};
  logic       tbl_cin[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  bit         m_act[2];
  int         m_t  [2];
  logic [3:0] m_sf [2];
  logic [3:0] m_cf [2];
  bit         m_fa [2];
  int         e0   [2];
  int         mk;
  logic [7:0] mg;

  int         q_ft[$];
  int         q_dt[$];
  logic [3:0] q_sf[$];
  logic [3:0] q_cf[$];
  bit         q_fa[$];
  int         l1[12];
  bit         f1[12];
  int         n_done1 = 0;

  rca_fault_sequencer #(.NUM_PAT(8), .SETTLE(2), .LOOP(0)) u_dut0 (
    .clk(clk), .clr(clr_v[0]), .start(start_v[0]), .hold(hold_v[0]),
    .dut_s(dut_s_v[0]), .dut_c(dut_c_v[0]),
    .pat_a(pat_a_v[0]), .pat_b(pat_b_v[0]), .pat_cin(pat_cin_v[0]), .lut_i(lut_i_v[0]),
    .sf(sf_v[0]), .cf(cf_v[0]), .flag_vld(flag_vld_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .fault_any(fault_any_v[0])
  );

  rca_fault_sequencer #(.NUM_PAT(3), .SETTLE(1), .LOOP(1)) u_dut1 (
    .clk(clk), .clr(clr_v[1]), .start(start_v[1]), .hold(hold_v[1]),
    .dut_s(dut_s_v[1]), .dut_c(dut_c_v[1]),
    .pat_a(pat_a_v[1]), .pat_b(pat_b_v[1]), .pat_cin(pat_cin_v[1]), .lut_i(lut_i_v[1]),
    .sf(sf_v[1]), .cf(cf_v[1]), .flag_vld(flag_vld_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .fault_any(fault_any_v[1])
  );

  // Golden per-stage sums/carries from plain addition: carry-out of stage i is bit i+1 of the
  // low (i+1)-bit partial sum.
  function automatic logic [7:0] gold(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] full;
    logic [4:0] part;
    logic [3:0] m;
    logic [7:0] r;
    full   = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    r[3:0] = full[3:0];
    for (int i = 0; i < 4; i++) begin
      m        = 4'((1 << (i + 1)) - 1);
      part     = {1'b0, a & m} + {1'b0, b & m} + {4'b0, cin};
      r[4 + i] = part[i + 1];
    end
    return r;
  endfunction

  // Adder under test: golden adder with optional stuck-at-0 bits on instance 0.
  assign {dut_c_v[0], dut_s_v[0]} = gold(pat_a_v[0], pat_b_v[0], pat_cin_v[0]) & ~{sa_c, sa_s};
  assign {dut_c_v[1], dut_s_v[1]} = gold(pat_a_v[1], pat_b_v[1], pat_cin_v[1]);

  function automatic int per_of(input int i);
    return (i == 0) ? 3 : 2;
  endfunction
  function automatic int npat_of(input int i);
    return (i == 0) ? 8 : 3;
  endfunction
  function automatic bit loop_of(input int i);
    return (i != 0);
  endfunction

  function automatic logic [23:0] act_bundle(input int i);
    return {pat_a_v[i], pat_b_v[i], pat_cin_v[i], lut_i_v[i], sf_v[i], cf_v[i],
            flag_vld_v[i], busy_v[i], done_v[i], fault_any_v[i]};
  endfunction

  function automatic logic [23:0] expect_out(input int i);
    int         p;
    int         n;
    int         idx;
    bit         act;
    bit         in_done;
    bit         fv;
    bit         dn;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ec;
    logic [2:0] el;
    p       = per_of(i);
    n       = npat_of(i);
    act     = m_act[i];
    in_done = act && !loop_of(i) && (m_t[i] == p * n);
    idx     = in_done ? n - 1 : (m_t[i] / p) % n;
    ea      = act ? tbl_a[idx] : 4'h0;
    eb      = act ? tbl_b[idx] : 4'h0;
    ec      = act ? tbl_cin[idx] : 1'b0;
    el      = act ? 3'(idx) : 3'd0;
    fv      = act && (m_t[i] > 0) && (m_t[i] % p == 0) && !hold_v[i];
    dn      = in_done && !hold_v[i];
    return {ea, eb, ec, el, m_sf[i], m_cf[i], fv, act, dn, m_fa[i]};
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < lim && !seen; n++) begin
      @(negedge clk);
      if (done_v[0]) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_rec();
    q_ft.delete(); q_dt.delete(); q_sf.delete(); q_cf.delete(); q_fa.delete();
  endtask

  task automatic chk_times(input string nm, input int extra);
    chk({nm, "_nflags"}, q_ft.size(), 8);
    for (int k = 0; k < q_ft.size(); k++)
      chk({nm, "_flag_t"}, q_ft[k], 3 * (k + 1) + ((k >= 3) ? extra : 0));
    chk({nm, "_ndone"}, q_dt.size(), 1);
    if (q_dt.size() > 0) chk({nm, "_done_t"}, q_dt[0], 24 + extra);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      clr_v[i] = 1'b1; start_v[i] = 1'b0; hold_v[i] = 1'b0;
    end
    sa_s = 4'h0;
    sa_c = 4'h0;
    fork
      // Reference model: advances on every edge not frozen by hold.
      forever begin
        @(posedge clk);
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
          if (clr_v[i]) begin
            m_act[i] = 0; m_t[i] = 0; m_sf[i] = 4'h0; m_cf[i] = 4'h0; m_fa[i] = 0;
          end else if (!hold_v[i]) begin
            if (!m_act[i]) begin
              if (start_v[i]) begin
                m_act[i] = 1; m_t[i] = 0; m_fa[i] = 0; e0[i] = cyc;
              end
            end else begin
              m_t[i] = m_t[i] + 1;
              if (!loop_of(i) && m_t[i] > per_of(i) * npat_of(i)) m_act[i] = 0;
              else if (m_t[i] % per_of(i) == 0) begin
                mk      = (m_t[i] / per_of(i) - 1) % npat_of(i);
                mg      = gold(tbl_a[mk], tbl_b[mk], tbl_cin[mk]);
                m_sf[i] = mg[3:0] & ((i == 0) ? sa_s : 4'h0);
                m_cf[i] = mg[7:4] & ((i == 0) ? sa_c : 4'h0);
                if ((m_sf[i] | m_cf[i]) != 4'h0) m_fa[i] = 1;
              end
            end
          end
        end
      end
      // Per-cycle compare and recording.
      forever begin
        @(negedge clk);
        if (chk_en) begin
          for (int i = 0; i < 2; i++) begin
            total++;
            if (act_bundle(i) !== expect_out(i)) begin
              bad++;
              $display("FAIL cycle_model dut%0d cyc=%0d got=%h want=%h", i, cyc, act_bundle(i), expect_out(i));
            end
          end
        end
        if (flag_vld_v[0]) begin
          q_ft.push_back(cyc - e0[0]); q_sf.push_back(sf_v[0]);
          q_cf.push_back(cf_v[0]);     q_fa.push_back(fault_any_v[0]);
        end
        if (done_v[0]) q_dt.push_back(cyc - e0[0]);
        if (done_v[1]) n_done1++;
        if (m_act[1] && (cyc - e0[1]) < 12) begin
          l1[cyc - e0[1]] = int'(lut_i_v[1]);
          f1[cyc - e0[1]] = flag_vld_v[1];
        end
      end
      begin
        @(posedge clk); chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 clr_v[0] = 1'b0; clr_v[1] = 1'b0;
        @(negedge clk);
        chk("reset_outs0", int'(act_bundle(0)), 0);
        chk("reset_outs1", int'(act_bundle(1)), 0);
        @(posedge clk); #1 start_v[1] = 1'b1;
        @(posedge clk); #1 start_v[1] = 1'b0;

        // Fault-free run.
        clear_rec(); do_start(); wait_done(100);
        chk_times("clean", 0);
        for (int k = 0; k < q_sf.size(); k++) chk("clean_sfcf", int'({q_sf[k], q_cf[k]}), 0);
        chk("clean_fault_any", int'(fault_any_v[0]), 0);

        // Sum bit 2 stuck at 0.
        sa_s = 4'b0100;
        clear_rec(); do_start(); wait_done(100);
        for (int k = 0; k < q_sf.size(); k++) begin
          chk("s2_sf", int'(q_sf[k]), (k == 2 || k == 3 || k == 7) ? 4 : 0);
          chk("s2_cf", int'(q_cf[k]), 0);
        end
        if (q_fa.size() == 8) begin
          chk("s2_fa_entry1", int'(q_fa[1]), 0);
          chk("s2_fa_entry2", int'(q_fa[2]), 1);
        end
        chk("s2_fault_any", int'(fault_any_v[0]), 1);
        sa_s = 4'h0;

        // Carry 0 stuck at 0.
        sa_c = 4'b0001;
        clear_rec(); do_start(); wait_done(100);
        for (int k = 0; k < q_cf.size(); k++) begin
          chk("c0_cf", int'(q_cf[k]), (k == 1 || k == 2 || k == 4 || k == 5 || k == 6) ? 1 : 0);
          chk("c0_sf", int'(q_sf[k]), 0);
        end
        chk("c0_fault_any", int'(fault_any_v[0]), 1);
        sa_c = 4'h0;

        // Hold for 5 cycles during entry 3 drive.
        clear_rec(); do_start();
        repeat (10) @(posedge clk);
        #1 hold_v[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1 hold_v[0] = 1'b0;
        wait_done(100);
        chk_times("hold", 5);

        // Clear during entry 4 drive, then a clean rerun.
        clear_rec(); do_start();
        repeat (13) @(posedge clk);
        #1 clr_v[0] = 1'b1;
        @(posedge clk); #1 clr_v[0] = 1'b0;
        @(negedge clk);
        chk("clr_outs", int'(act_bundle(0)), 0);
        chk("clr_nflags", q_ft.size(), 4);
        chk("clr_ndone", q_dt.size(), 0);
        clear_rec(); do_start(); wait_done(100);
        chk_times("rerun", 0);
        chk("rerun_fault_any", int'(fault_any_v[0]), 0);

        // Looping instance: lut 0,1,2,0,1,2 with a strobe every 2 cycles, never done.
        for (int j = 0; j < 6; j++) begin
          chk("loop_lut", l1[2 * j], j % 3);
          chk("loop_flag", int'(f1[2 * j]), (j > 0) ? 1 : 0);
          chk("loop_flag_odd", int'(f1[2 * j + 1]), 0);
        end
        chk("loop_busy", int'(busy_v[1]), 1);
        chk("loop_no_done", n_done1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join
  end

endmodule
